mux_4_1_rr_arbiter: RTL and testbench
=====================================

Name: mux_4_1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux (select inputs s1/s0, data inputs i0..i3) among four requesters.
- Requester k drives mux input ik; the arbiter grants one requester at a time.
- It drives s1/s0 so the mux output carries the granted requester's data.
- Grant tenure is bounded by MAX_HOLD so no requester can starve the others.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester keeps the grant while others wait. Legal range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request vector; req[k] requests mux input ik. Level-sensitive; held high for the whole transfer.
- grant  output  4  one-hot grant, or all-zero when idle. Registered.
- s1  output  1  mux select MSB = bit 1 of the granted index. Registered.
- s0  output  1  mux select LSB = bit 0 of the granted index. Registered.
- busy  output  1  high while any grant is active. Equals OR of grant.
- hold_cnt  output  CNT_W  cycles the current grant has been held, counting from 1. Zero when idle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant=0000, s1=0, s0=0, busy=0, hold_cnt=0.
  - state=IDLE, internal pointer ptr=3, so requester 0 has top priority after reset.
  - Reset overrides every other event on the same edge, including mid-grant.
- Winner selection: scan indices ptr+1, ptr+2, ptr+3, ptr+4 (mod 4) and take the first with req set.
- IDLE:
  - If req==0000: remain in IDLE; all outputs hold; s1/s0 keep their last value so the mux stays stable.
  - If req!=0000: next edge goes to GRANT. grant=onehot(winner), {s1,s0}=winner, busy=1, hold_cnt=1.
  - Latency: grant is visible on the edge after the request is sampled.
- GRANT, current index g, evaluated every edge:
  - a) req[g]=0 (release): ptr<=g.
    - If any other req is set, grant the next winner scanned from g+1 on that same edge (no idle bubble); hold_cnt=1.
    - Otherwise go to IDLE: grant=0000, busy=0, hold_cnt=0, s1/s0 held.
  - b) req[g]=1, hold_cnt==MAX_HOLD, another req set (preempt): ptr<=g; grant the winner scanned from g+1 (never g itself); hold_cnt=1.
  - c) req[g]=1, hold_cnt==MAX_HOLD, no other req: keep the grant; hold_cnt saturates at MAX_HOLD.
  - d) Otherwise: keep the grant; hold_cnt+1.
- Invariants:
  - grant is always one-hot or zero.
  - {s1,s0} equals the index of the set grant bit whenever busy=1.
  - s1/s0 change only on an edge where grant changes to a new nonzero value.
- Wrap-around: the scan from g+1 wraps 3->0.
- Simultaneous requests: a requester raising req on the same edge another releases is eligible in that edge's scan.
- MAX_HOLD=1: every edge with competing requests rotates the grant.

Test Plan:
- Reset then req=0001: the edge after req is sampled gives grant=0001, s1s0=00, busy=1, hold_cnt=1. Drop req at cycle 3 -> next edge grant=0000, busy=0, s1s0 stays 00.
- req=1111 held constantly, MAX_HOLD=4: grants rotate 0001 (4 cycles) -> 0010 (4) -> 0100 (4) -> 1000 (4) -> 0001, with s1s0 00,01,10,11. hold_cnt counts 1..4 in each tenure.
- Only req[2]=1 for 10 cycles: grant=0100 throughout, s1s0=10, hold_cnt saturates at 4.
- Grant on 3; req[3] drops on the same edge req[0] rises -> next edge grant=0001, s1s0=00, hold_cnt=1, with no idle cycle (wrap 3->0).
- rst asserted while grant=0100, hold_cnt=2 -> next edge grant=0000, s1s0=00, hold_cnt=0. Then req=1111 -> first grant is 0001.
- Each requester pulses a single-cycle req in turn (0001, 0010, 0100, 1000) -> each gets exactly one grant with the correct s1s0. Release returns to IDLE between pulses.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Grant tenure is bounded by MAX_HOLD cycles whenever another requester is waiting.
module mux_4_1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic             s1,
    output logic             s0,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_r;
    logic [1:0]       ptr_r;
    logic [1:0]       sel_r;
    logic [3:0]       grant_r;
    logic             busy_r;
    logic [CNT_W-1:0] hold_r;

    logic [3:0]       scan_vec_s;
    logic [1:0]       scan_base_s;
    logic [2:0]       pick_s;
    logic             win_valid_s;
    logic [1:0]       win_idx_s;
    logic             at_limit_s;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Returns {found, index}; offsets are walked farthest-first so the nearest
    // requester after base wins, with base itself considered last.
    function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Scan source: from the pointer when idle, from the holder (excluded) when granting.
    always_comb begin
        scan_vec_s  = req;
        scan_base_s = ptr_r;
        if (state_r == ST_GRANT) begin
            scan_vec_s  = req & ~onehot(sel_r);
            scan_base_s = sel_r;
        end else begin
            scan_vec_s  = req;
            scan_base_s = ptr_r;
        end
    end

    assign pick_s      = rr_pick(scan_vec_s, scan_base_s);
    assign win_valid_s = pick_s[2];
    assign win_idx_s   = pick_s[1:0];
    assign at_limit_s  = (hold_r >= CNT_W'(MAX_HOLD));

    // Arbitration state machine with registered grant, select, busy and hold count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd3;
            sel_r   <= 2'd0;
            grant_r <= 4'b0000;
            busy_r  <= 1'b0;
            hold_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        state_r <= ST_GRANT;
                        sel_r   <= win_idx_s;
                        grant_r <= onehot(win_idx_s);
                        busy_r  <= 1'b1;
                        hold_r  <= CNT_W'(1);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!req[sel_r]) begin
                        ptr_r <= sel_r;
                        if (win_valid_s) begin
                            sel_r   <= win_idx_s;
                            grant_r <= onehot(win_idx_s);
                            hold_r  <= CNT_W'(1);
                        end else begin
                            state_r <= ST_IDLE;
                            grant_r <= 4'b0000;
                            busy_r  <= 1'b0;
                            hold_r  <= '0;
                        end
                    end else if (at_limit_s) begin
                        // Tenure exhausted: rotate only if someone else is waiting.
                        if (win_valid_s) begin
                            ptr_r   <= sel_r;
                            sel_r   <= win_idx_s;
                            grant_r <= onehot(win_idx_s);
                            hold_r  <= CNT_W'(1);
                        end else begin
                            hold_r  <= CNT_W'(MAX_HOLD);
                        end
                    end else begin
                        hold_r <= hold_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= 4'b0000;
                    busy_r  <= 1'b0;
                    hold_r  <= '0;
                end
            endcase
        end
    end

    assign grant    = grant_r;
    assign s1       = sel_r[1];
    assign s0       = sel_r[0];
    assign busy     = busy_r;
    assign hold_cnt = hold_r;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Table-driven bench for mux_4_1_rr_arbiter (MAX_HOLD=4) with a few
// hand-written multi-cycle sequences.
module tb_mux_4_1_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       s1;
    logic       s0;
    logic       busy;
    logic [7:0] hold_cnt;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic [7:0] hold;
    } vec_t;

    vec_t vecs[$];

    mux_4_1_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .s1       (s1),
        .s0       (s0),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    function automatic void add(input string n, input logic r, input logic [3:0] rq,
                                input logic [3:0] g, input logic [1:0] sl,
                                input logic b, input logic [7:0] h);
        vec_t v;
        v.name = n; v.rst = r; v.req = rq; v.grant = g; v.sel = sl; v.busy = b; v.hold = h;
        vecs.push_back(v);
    endfunction

    task automatic check(input string n, input logic [3:0] g, input logic [1:0] sl,
                         input logic b, input logic [7:0] h);
        checks++;
        if (grant !== g || {s1, s0} !== sl || busy !== b || hold_cnt !== h) begin
            $display("FAIL %s: got grant=%b s1s0=%b%b busy=%b hold=%0d, want grant=%b s1s0=%b busy=%b hold=%0d",
                     n, grant, s1, s0, busy, hold_cnt, g, sl, b, h);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [1:0] gi;
        clk = 1'b0;
        rst = 1'b1;
        req = 4'b0000;

        // single requester, then release
        add("reset",        1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);
        add("single_g1",    1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 8'd1);
        add("single_g2",    1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 8'd2);
        add("single_drop",  1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);
        add("idle_hold",    1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);
        // full rotation with all requesting
        add("reset2",       1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);
        for (int t = 0; t < 17; t++) begin
            gi = 2'((t / 4) % 4);
            add("rotate", 1'b0, 4'b1111, 4'b0001 << gi, gi, 1'b1, 8'((t % 4) + 1));
        end
        // lone requester saturates
        for (int t = 0; t < 10; t++) begin
            add("lone_sat", 1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, (t < 4) ? 8'(t + 1) : 8'd4);
        end
        add("lone_drop",    1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, 8'd0);
        // release on 3 while 0 rises: wrap without idle bubble
        add("wrap_g3",      1'b0, 4'b1000, 4'b1000, 2'b11, 1'b1, 8'd1);
        add("wrap_g3b",     1'b0, 4'b1000, 4'b1000, 2'b11, 1'b1, 8'd2);
        add("wrap_to0",     1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, 8'd1);
        add("wrap_idle",    1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);
        // reset mid-grant
        add("mid_g2",       1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, 8'd1);
        add("mid_g2b",      1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, 8'd2);
        add("mid_rst",      1'b1, 4'b0100, 4'b0000, 2'b00, 1'b0, 8'd0);
        add("post_rst_all", 1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1, 8'd1);
        add("post_rst_idl", 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);
        // single-cycle pulses from each requester
        for (int k = 0; k < 4; k++) begin
            gi = 2'(k);
            add("pulse_grant", 1'b0, 4'b0001 << gi, 4'b0001 << gi, gi, 1'b1, 8'd1);
            add("pulse_idle",  1'b0, 4'b0000, 4'b0000, gi, 1'b0, 8'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req);
            check(vecs[i].name, vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].hold);
        end

        // preempt from 0 skips idle requesters 1,2 and lands on 3 after 4 held cycles
        step(1'b1, 4'b0000);
        check("seq_reset", 4'b0000, 2'b00, 1'b0, 8'd0);
        n = 0;
        rst = 1'b0;
        req = 4'b1001;
        while (grant !== 4'b1000 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 5) begin
            $display("FAIL preempt_latency: got %0d edges, want 5", n);
        end else begin
            passed++;
        end
        check("preempt_to3", 4'b1000, 2'b11, 1'b1, 8'd1);
        // 3 releases while 0 and 1 wait: scan wraps to 0
        step(1'b0, 4'b0011);
        check("rel_wrap0", 4'b0001, 2'b00, 1'b1, 8'd1);
        // 0 releases while 1 waits: immediate hand-off
        step(1'b0, 4'b0010);
        check("rel_to1", 4'b0010, 2'b01, 1'b1, 8'd1);
        step(1'b0, 4'b0110);
        check("hold_1_2", 4'b0010, 2'b01, 1'b1, 8'd2);
        step(1'b0, 4'b0000);
        check("final_idle", 4'b0000, 2'b01, 1'b0, 8'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
